// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM-style main controller: states, mux selects, opcodes
// and the bundle of control strobes produced by the output decode.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        SrcARn     = 2'b00,
        SrcAPc     = 2'b01,
        SrcAAluOut = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SrcBRm     = 2'b00,
        SrcBExtImm = 2'b01,
        SrcBFour   = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResData      = 2'b01,
        ResAluResult = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        OpDataProc = 2'b00,
        OpMemory   = 2'b01,
        OpBranch   = 2'b10,
        OpUndef    = 2'b11
    } op_e;

    localparam int unsigned FunctImmBit  = 5;
    localparam int unsigned FunctLoadBit = 0;

    typedef struct packed {
        logic        ir_write;
        logic        next_pc;
        logic        adr_src;
        alu_src_a_e  alu_src_a;
        alu_src_b_e  alu_src_b;
        result_src_e result_src;
        logic        alu_op;
        logic        reg_w;
        logic        mem_w;
        logic        branch;
    } ctrl_t;

    // A return to FETCH from one of these states completes an instruction; DECODE does not.
    function automatic logic retires_from(state_e s);
        return (s == StMemWb) || (s == StMemWr) || (s == StAluWb) || (s == StBranch);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode for the main controller; mem_ready only qualifies the one-shot strobes.
module mc_ctrl_decode
    import arm_mc_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            StFetch: begin
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.next_pc    = mem_ready_i;
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.alu_src_a  = SrcAPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.result_src = ResAluResult;
                ctrl_o.alu_op     = 1'b0;
            end
            StDecode: begin
                ctrl_o.alu_src_a  = SrcAPc;
                ctrl_o.alu_src_b  = SrcBFour;
                ctrl_o.result_src = ResAluResult;
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = SrcARn;
                ctrl_o.alu_src_b = SrcBExtImm;
                ctrl_o.alu_op    = 1'b0;
            end
            StMemRd: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = ResAluOut;
            end
            StMemWb: begin
                ctrl_o.result_src = ResData;
                ctrl_o.reg_w      = 1'b1;
            end
            StMemWr: begin
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.result_src = ResAluOut;
                // Single write pulse on the completing cycle only.
                ctrl_o.mem_w      = mem_ready_i;
            end
            StExecuteR: begin
                ctrl_o.alu_src_a = SrcARn;
                ctrl_o.alu_src_b = SrcBRm;
                ctrl_o.alu_op    = 1'b1;
            end
            StExecuteI: begin
                ctrl_o.alu_src_a = SrcARn;
                ctrl_o.alu_src_b = SrcBExtImm;
                ctrl_o.alu_op    = 1'b1;
            end
            StAluWb: begin
                ctrl_o.result_src = ResAluOut;
                ctrl_o.reg_w      = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a  = SrcAAluOut;
                ctrl_o.alu_src_b  = SrcBExtImm;
                ctrl_o.result_src = ResAluResult;
                ctrl_o.branch     = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// Main sequencing FSM of the multicycle controller with a retired-instruction counter.
module mc_main_fsm
    import arm_mc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             next_pc,
    output logic             adr_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic             alu_op,
    output logic             reg_w,
    output logic             mem_w,
    output logic             branch,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    ctrl_t              ctrl;
    logic               unused_funct;

    // Only the immediate and load/store flags steer the sequence.
    assign unused_funct = ^funct[4:1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (op)
                    OpDataProc: state_d = funct[FunctImmBit] ? StExecuteI : StExecuteR;
                    OpMemory:   state_d = StMemAdr;
                    OpBranch:   state_d = StBranch;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = funct[FunctLoadBit] ? StMemRd : StMemWr;
            StMemRd:    if (mem_ready) state_d = StMemWb;
            StMemWr:    if (mem_ready) state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StMemWb:    state_d = StFetch;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if ((state_d == StFetch) && retires_from(state_q)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    mc_ctrl_decode u_ctrl_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign ir_write   = ctrl.ir_write;
    assign next_pc    = ctrl.next_pc;
    assign adr_src    = ctrl.adr_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign alu_op     = ctrl.alu_op;
    assign reg_w      = ctrl.reg_w;
    assign mem_w      = ctrl.mem_w;
    assign branch     = ctrl.branch;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed bench for mc_main_fsm; a 4-bit counter keeps the wrap scenario short.
module tb_mc_main_fsm;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [5:0]    funct = 6'b000000;
    logic          mem_ready = 1'b0;
    logic          ir_write, next_pc, adr_src, alu_op, reg_w, mem_w, branch;
    logic [1:0]    alu_src_a, alu_src_b, result_src;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int n_vec = 0;
    int n_err = 0;

    mc_main_fsm #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_ready = 1'b0; op = 2'b00; funct = 6'b0;
        tick(); tick();
        reset = 1'b0; #1;
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", state); end
        n_vec++; if (retired !== 4'd0) begin n_err++; $display("FAIL reset_retired got %0d exp 0", retired); end
        n_vec++;
        if ({ir_write, next_pc, mem_w, reg_w, branch} !== 5'b00000) begin
            n_err++; $display("FAIL reset_strobes got %b exp 00000", {ir_write, next_pc, mem_w, reg_w, branch});
        end
        n_vec++;
        if ({adr_src, alu_src_a, alu_src_b, result_src, alu_op} !== 8'b0_01_10_10_0) begin
            n_err++; $display("FAIL reset_fetch_decode got %b exp 00110100",
                              {adr_src, alu_src_a, alu_src_b, result_src, alu_op});
        end
        tick();
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL fetch_hold got %0d exp 0", state); end
    endtask

    task automatic test_data_proc;
        logic [3:0] exp_st [4];
        logic       exp_rw [4];
        exp_st = '{4'd1, 4'd6, 4'd8, 4'd0};
        exp_rw = '{1'b0, 1'b0, 1'b1, 1'b0};
        op = 2'b00; funct = 6'b000000; mem_ready = 1'b1; #1;
        n_vec++;
        if ({ir_write, next_pc} !== 2'b11) begin
            n_err++; $display("FAIL dp_fetch_pulse got %b exp 11", {ir_write, next_pc});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (state !== exp_st[i]) begin
                n_err++; $display("FAIL dp_state[%0d] got %0d exp %0d", i, state, exp_st[i]);
            end
            n_vec++;
            if (reg_w !== exp_rw[i]) begin
                n_err++; $display("FAIL dp_reg_w[%0d] got %b exp %b", i, reg_w, exp_rw[i]);
            end
            if (i == 1) begin
                n_vec++;
                if ({alu_op, alu_src_a, alu_src_b} !== 5'b1_00_00) begin
                    n_err++; $display("FAIL dp_execr got %b exp 10000", {alu_op, alu_src_a, alu_src_b});
                end
            end
        end
        n_vec++; if (retired !== 4'd1) begin n_err++; $display("FAIL dp_retired got %0d exp 1", retired); end
    endtask

    task automatic test_load;
        op = 2'b01; funct = 6'b000001; mem_ready = 1'b1;
        tick(); tick();
        n_vec++; if (state !== 4'd2) begin n_err++; $display("FAIL ld_memadr got %0d exp 2", state); end
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            // Garbage on op/funct outside DECODE/MEMADR must be ignored.
            op = 2'b11; funct = 6'b111110;
            n_vec++;
            if (state !== 4'd3) begin n_err++; $display("FAIL ld_wait[%0d] got %0d exp 3", i, state); end
            n_vec++;
            if (ir_write !== 1'b0) begin n_err++; $display("FAIL ld_wait_irw[%0d] got %b exp 0", i, ir_write); end
        end
        mem_ready = 1'b1;
        tick();
        n_vec++; if (state !== 4'd4) begin n_err++; $display("FAIL ld_memwb got %0d exp 4", state); end
        n_vec++;
        if ({result_src, reg_w} !== 3'b01_1) begin
            n_err++; $display("FAIL ld_wb_ctrl got %b exp 011", {result_src, reg_w});
        end
        tick();
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL ld_done got %0d exp 0", state); end
        n_vec++; if (retired !== 4'd2) begin n_err++; $display("FAIL ld_retired got %0d exp 2", retired); end
    endtask

    task automatic test_store;
        op = 2'b01; funct = 6'b000000; mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({state, mem_w, adr_src} !== {4'd5, 1'b0, 1'b1}) begin
                n_err++; $display("FAIL st_wait[%0d] got st=%0d mem_w=%b adr=%b exp st=5 mem_w=0 adr=1",
                                  i, state, mem_w, adr_src);
            end
        end
        mem_ready = 1'b1; #1;
        n_vec++; if (mem_w !== 1'b1) begin n_err++; $display("FAIL st_pulse got %b exp 1", mem_w); end
        tick();
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL st_done got %0d exp 0", state); end
        n_vec++; if (mem_w !== 1'b0) begin n_err++; $display("FAIL st_pulse_end got %b exp 0", mem_w); end
        n_vec++; if (retired !== 4'd3) begin n_err++; $display("FAIL st_retired got %0d exp 3", retired); end
    endtask

    task automatic test_branch;
        op = 2'b10; funct = 6'b000000; mem_ready = 1'b1;
        tick();
        n_vec++; if (state !== 4'd1) begin n_err++; $display("FAIL br_decode got %0d exp 1", state); end
        tick();
        n_vec++; if (state !== 4'd9) begin n_err++; $display("FAIL br_state got %0d exp 9", state); end
        n_vec++;
        if ({branch, alu_src_a} !== 3'b1_10) begin
            n_err++; $display("FAIL br_ctrl got %b exp 110", {branch, alu_src_a});
        end
        tick();
        n_vec++;
        if ({state, branch} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL br_done got st=%0d br=%b exp st=0 br=0", state, branch);
        end
        n_vec++; if (retired !== 4'd4) begin n_err++; $display("FAIL br_retired got %0d exp 4", retired); end
    endtask

    task automatic test_undef_and_reset;
        op = 2'b11; mem_ready = 1'b1;
        tick(); tick();
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL undef_state got %0d exp 0", state); end
        n_vec++; if (retired !== 4'd4) begin n_err++; $display("FAIL undef_retired got %0d exp 4", retired); end
        op = 2'b01; funct = 6'b000001;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        n_vec++; if (state !== 4'd3) begin n_err++; $display("FAIL rst_pre got %0d exp 3", state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (state !== 4'd0) begin n_err++; $display("FAIL rst_midwait got %0d exp 0", state); end
        n_vec++; if (retired !== 4'd0) begin n_err++; $display("FAIL rst_retired got %0d exp 0", retired); end
    endtask

    task automatic test_wrap;
        op = 2'b10; mem_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick(); tick(); tick();
        end
        n_vec++; if (retired !== 4'hF) begin n_err++; $display("FAIL wrap_full got %0d exp 15", retired); end
        tick(); tick(); tick();
        n_vec++; if (retired !== 4'd0) begin n_err++; $display("FAIL wrap_zero got %0d exp 0", retired); end
    endtask

    initial begin
        test_reset();
        test_data_proc();
        test_load();
        test_store();
        test_branch();
        test_undef_and_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 Parameters SHALL be: CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  2  instruction bits [27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 funct  input  6  instruction bits [25:20]; funct[5] is the immediate flag, funct[0] is load/store (1 = load).
REQ-006 mem_ready  input  1  memory completion handshake for the current fetch, read or write.
REQ-007 ir_write  output  1  instruction-register load strobe.
REQ-008 next_pc  output  1  PC+4 update strobe.
REQ-009 adr_src  output  1  0 = PC address, 1 = ALU-result address.
REQ-010 alu_src_a  output  2  00 = Rn, 01 = PC, 10 = ALUOut.
REQ-011 alu_src_b  output  2  00 = Rm, 01 = ExtImm, 10 = constant 4.
REQ-012 result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALU result.
REQ-013 alu_op  output  1  1 = decode ALU function from funct; 0 = force ADD.
REQ-014 reg_w, mem_w, branch  output  1 each  raw write and branch requests; these go to the downstream conditional logic, which gates them.
REQ-015 state  output  4  current state encoding, used for debug.
REQ-016 retired  output  CNT_W  count of completed instructions.

Function
REQ-017 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, encoded 0 to 9 in that order.
REQ-018 Transitions SHALL be as follows.
- FETCH goes to DECODE on mem_ready and otherwise holds.
- DECODE goes to MEMADR when op=01.
- DECODE goes to EXECUTER when op=00 and funct[5]=0, and to EXECUTEI when op=00 and funct[5]=1.
- DECODE goes to BRANCH when op=10, and to FETCH when op=11.
REQ-019 Remaining transitions SHALL be as follows.
- MEMADR goes to MEMRD when funct[0]=1 and to MEMWR when funct[0]=0.
- MEMRD goes to MEMWB on mem_ready and otherwise holds.
- MEMWR goes to FETCH on mem_ready and otherwise holds.
- EXECUTER and EXECUTEI go to ALUWB.
- MEMWB, ALUWB and BRANCH go to FETCH.
REQ-020 Outputs SHALL be Moore-decoded from state; any output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10, alu_op=0.
- DECODE: alu_src_a=01, alu_src_b=10, result_src=10.
- MEMADR: alu_src_a=00, alu_src_b=01, alu_op=0.
- MEMRD: adr_src=1, result_src=00.
- MEMWB: result_src=01, reg_w=1.
- MEMWR: adr_src=1, result_src=00.
- EXECUTER: alu_src_a=00, alu_src_b=00, alu_op=1.
- EXECUTEI: alu_src_a=00, alu_src_b=01, alu_op=1.
- ALUWB: result_src=00, reg_w=1.
- BRANCH: alu_src_a=10, alu_src_b=01, result_src=10, branch=1.
REQ-021 ir_write and next_pc SHALL assert only in FETCH and only while mem_ready=1, giving exactly one pulse per fetch regardless of wait cycles.
REQ-022 mem_w SHALL assert only in MEMWR while mem_ready=1, giving exactly one write pulse per store.
REQ-023 op and funct SHALL be sampled only in DECODE and MEMADR; changes on them in any other state SHALL have no effect.
REQ-024 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH; the DECODE-to-FETCH transition (op=11) SHALL NOT increment it.
REQ-025 retired SHALL wrap from all ones to 0.
REQ-026 Instruction latencies with mem_ready held at 1 SHALL be: data-processing 4 cycles, load 5, store 4, branch 3.

Reset
REQ-027 While reset=1, the FSM SHALL go to FETCH and retired SHALL go to 0 on the next clock edge, taking priority over every transition, including one in the middle of a wait state.
REQ-028 After reset, outputs SHALL equal the FETCH decode; with mem_ready=0, ir_write, next_pc, mem_w, reg_w and branch SHALL be 0.

Structure
REQ-029 The state enum, the alu_src_a, alu_src_b and result_src encodings, and the op encodings SHALL live in the shared package arm_mc_pkg.
REQ-030 The output decode SHALL be one combinational sub-module, mc_ctrl_decode, whose inputs are state and mem_ready.

Verification
REQ-031 The bench SHALL cover the following directed scenarios.
- Reset, then op=00 with funct=000000 and mem_ready=1 → states 0,1,6,8,0; reg_w=1 only in ALUWB; retired=1.
- op=01, funct[0]=1, with mem_ready=0 for 3 cycles in MEMRD → state holds at 3; MEMWB follows one cycle after mem_ready rises; load total 8 cycles.
- op=01, funct[0]=0, with mem_ready=0 for 2 cycles in MEMWR → mem_w=0 during the wait; one single-cycle mem_w pulse; then FETCH.
- op=10 → states 0,1,9,0; branch=1 for one cycle; alu_src_a=10.
- op=11 → DECODE goes to FETCH; retired unchanged; reset asserted in MEMRD → FETCH next cycle and retired=0.
- Preload retired to all ones, then complete one instruction → retired=0.
